// File: rtl/soc_mem_arbiter.sv
// Memory front-end: serialises FETCH_N-word instruction fetches and single-word
// data accesses from the CPU onto one shared memory req/ack beat handshake.
module soc_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int FETCH_N = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      i_flush,
  output logic [FETCH_N*DATA_W-1:0] i_data,
  output logic [FETCH_N*ADDR_W-1:0] i_addr_o,
  output logic                      i_valid,
  output logic                      i_stall,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [DATA_W-1:0]         d_wdata,
  input  logic [DATA_W/8-1:0]       d_sel,
  output logic [DATA_W-1:0]         d_rdata,
  output logic                      d_valid,
  output logic                      d_stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_sel,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack
);

  localparam int SEL_W = DATA_W / 8;
  localparam int K_W   = (FETCH_N > 1) ? $clog2(FETCH_N) : 1;

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t         state_reg;
  logic [K_W-1:0] beat_reg;
  logic           prio_reg;
  logic           flush_pend_reg;

  logic beat_done;
  logic last_beat;
  logic cancel;
  logic d_ok;
  logic i_ok;
  logic d_take;
  logic i_take;
  logic word_we;

  // Byte offsets never reach the word-aligned memory bus.
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, i_addr[1:0], d_addr[1:0]};

  assign i_stall = i_req && !i_valid;
  assign d_stall = d_req && !d_valid;

  assign beat_done = mem_req && mem_ack;
  assign last_beat = (beat_reg == K_W'(FETCH_N - 1));
  assign cancel    = flush_pend_reg || i_flush;
  assign word_we   = (state_reg == I_ACC) && beat_done;

  // A port whose valid is high this cycle is still holding its old request,
  // so it is not eligible until the following cycle.
  always_comb begin
    d_ok   = d_req && !d_valid;
    i_ok   = i_req && !i_flush && !i_valid;
    d_take = d_ok && (!i_ok || !prio_reg);
    i_take = i_ok && !d_take;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      prio_reg       <= 1'b0;
      flush_pend_reg <= 1'b0;
      i_valid        <= 1'b0;
      d_valid        <= 1'b0;
      d_rdata        <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_sel        <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          flush_pend_reg <= 1'b0;
          beat_reg       <= '0;
          if (d_take) begin
            state_reg <= D_ACC;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= d_we ? d_wdata : '0;
            mem_sel   <= d_we ? d_sel : {SEL_W{1'b1}};
          end else if (i_take) begin
            state_reg <= I_ACC;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= '0;
            mem_sel   <= {SEL_W{1'b1}};
          end
        end
        D_ACC: begin
          if (beat_done) begin
            mem_req   <= 1'b0;
            if (!mem_we) d_rdata <= mem_rdata;
            d_valid   <= 1'b1;
            prio_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        I_ACC: begin
          if (i_flush) flush_pend_reg <= 1'b1;
          if (beat_done) begin
            if (last_beat || cancel) begin
              mem_req   <= 1'b0;
              i_valid   <= !cancel;
              prio_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              beat_reg <= beat_reg + 1'b1;
              mem_addr <= mem_addr + ADDR_W'(4);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-word fetch result registers, loaded as each beat of a burst lands.
  genvar gi;
  generate
    for (gi = 0; gi < FETCH_N; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;
      logic [ADDR_W-1:0] waddr_reg;
      always_ff @(posedge clk) begin
        if (!rst) begin
          word_reg  <= '0;
          waddr_reg <= '0;
        end else if (word_we && (beat_reg == K_W'(gi))) begin
          word_reg  <= mem_rdata;
          waddr_reg <= mem_addr;
        end
      end
      assign i_data[gi*DATA_W +: DATA_W]   = word_reg;
      assign i_addr_o[gi*ADDR_W +: ADDR_W] = waddr_reg;
    end
  endgenerate

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Randomised self-checking bench for soc_mem_arbiter with a wait-state memory
// responder and an array-based reference memory.
module tb_soc_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FN = 2;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_req = 1'b0, i_flush = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [FN*DW-1:0] i_data;
  logic [FN*AW-1:0] i_addr_o;
  logic i_valid, i_stall;
  logic d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [SW-1:0] d_sel = '0;
  logic [DW-1:0] d_rdata;
  logic d_valid, d_stall;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_ack = 1'b0;

  always #5 clk = ~clk;

  soc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FETCH_N(FN)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_data(i_data),
    .i_addr_o(i_addr_o), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
  } beat_t;

  beat_t beats[$];
  logic [DW-1:0] bus_mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];

  int wait_n = 0;
  bit spur_en = 1'b0;
  int stab_viol = 0;
  int ovl_viol = 0;

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction
  function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : fill(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Memory responder plus protocol monitors, all on the falling edge.
  int wcnt = 0;
  bit prev_pend = 1'b0;
  bit prev_iv = 1'b0, prev_dv = 1'b0;
  beat_t saved;
  always @(negedge clk) begin
    beat_t cur;
    bit ack_real;
    cur = '{addr: mem_addr, we: mem_we, sel: mem_sel, wdata: mem_wdata};
    if (prev_pend && rst && mem_req && cur != saved) stab_viol++;
    if (prev_pend && rst && !mem_req) stab_viol++;
    if (i_valid && d_valid) ovl_viol++;
    if ((i_valid && prev_iv) || (d_valid && prev_dv)) ovl_viol++;
    prev_iv = i_valid;
    prev_dv = d_valid;
    ack_real = 1'b0;
    mem_ack = 1'b0;
    if (rst && mem_req) begin
      if (wcnt >= wait_n) begin
        ack_real = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = bus_rd(mem_addr);
        beats.push_back(cur);
        if (mem_we) bus_mem[mem_addr] = merge(bus_rd(mem_addr), mem_wdata, mem_sel);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (spur_en && $urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
    end
    prev_pend = rst && mem_req && !ack_real;
    saved = cur;
  end

  task automatic do_data(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] sel, output logic [DW-1:0] rdata,
                         output int lat, output bit ok);
    d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel; d_req = 1'b1;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 80) begin
      @(negedge clk);
      lat++;
      if (d_valid) ok = 1'b1;
    end
    rdata = d_rdata;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [AW-1:0] addr, output logic [FN*DW-1:0] data,
                          output logic [FN*AW-1:0] addrs, output int lat, output bit ok);
    i_addr = addr; i_req = 1'b1;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 80) begin
      @(negedge clk);
      lat++;
      if (i_valid) ok = 1'b1;
    end
    data = i_data;
    addrs = i_addr_o;
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_total++; if ({mem_req, mem_we, i_valid, d_valid} !== 4'b0) $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, mem_we, i_valid, d_valid}); else n_pass++;
    n_total++; if (i_data !== '0 || i_addr_o !== '0) $display("FAIL reset_idata got=%h/%h exp=0", i_data, i_addr_o); else n_pass++;
    n_total++; if (d_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0 || mem_sel !== '0) $display("FAIL reset_dbus got=%h %h %h %h exp=0", d_rdata, mem_addr, mem_wdata, mem_sel); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_fetch_basic;
    int lat;
    bit ok;
    bus_mem[32'h1000] = 32'hAAAA0001; bus_mem[32'h1004] = 32'hAAAA0002;
    ref_mem[32'h1000] = 32'hAAAA0001; ref_mem[32'h1004] = 32'hAAAA0002;
    wait_n = 0; beats.delete();
    i_addr = 32'h1000; i_req = 1'b1;
    #1;
    n_total++; if (i_stall !== 1'b1) $display("FAIL fetch_stall_t got=%b exp=1", i_stall); else n_pass++;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 40) begin
      @(negedge clk);
      lat++;
      if (i_valid) ok = 1'b1;
      else begin
        n_total++; if (i_stall !== 1'b1) $display("FAIL fetch_stall cyc=%0d got=%b exp=1", lat, i_stall); else n_pass++;
      end
    end
    n_total++; if (!ok || lat != 3) $display("FAIL fetch_latency got=%0d ok=%0d exp=3", lat, ok); else n_pass++;
    n_total++; if (i_stall !== 1'b0) $display("FAIL fetch_stall_valid got=%b exp=0", i_stall); else n_pass++;
    n_total++; if (i_data !== {32'hAAAA0002, 32'hAAAA0001}) $display("FAIL fetch_data got=%h exp=aaaa0002aaaa0001", i_data); else n_pass++;
    n_total++; if (i_addr_o !== {32'h1004, 32'h1000}) $display("FAIL fetch_addr_o got=%h exp=0000100400001000", i_addr_o); else n_pass++;
    i_req = 1'b0;
    @(negedge clk);
    n_total++; if (beats.size() != 2 || beats[0].addr !== 32'h1000 || beats[1].addr !== 32'h1004 || beats[0].we !== 1'b0)
      $display("FAIL fetch_beats got n=%0d exp 2 beats at 1000,1004", beats.size()); else n_pass++;
    $display("fetch_basic: lat=%0d data=%h", lat, i_data);
  endtask

  task automatic test_data_wait;
    logic [DW-1:0] rd;
    int lat;
    bit ok;
    wait_n = 2; beats.delete();
    do_data(1'b1, 32'h2002, 32'h12345678, 4'b0011, rd, lat, ok);
    ref_mem[32'h2000] = merge(ref_rd(32'h2000), 32'h12345678, 4'b0011);
    n_total++; if (!ok || lat != 4) $display("FAIL wr_latency got=%0d exp=4", lat); else n_pass++;
    n_total++; if (beats.size() != 1 || beats[0].addr !== 32'h2000 || beats[0].sel !== 4'b0011 || beats[0].we !== 1'b1 || beats[0].wdata !== 32'h12345678)
      $display("FAIL wr_beat got n=%0d exp addr 2000 sel 3 we 1", beats.size()); else n_pass++;
    n_total++; if (rd !== '0) $display("FAIL wr_rdata_kept got=%h exp=0", rd); else n_pass++;
    bus_mem[32'h3000] = 32'hDEADBEEF; ref_mem[32'h3000] = 32'hDEADBEEF;
    do_data(1'b0, 32'h3000, 32'h0, 4'b0000, rd, lat, ok);
    n_total++; if (!ok || lat != 4 || rd !== 32'hDEADBEEF) $display("FAIL rd_deadbeef got=%h lat=%0d exp=deadbeef lat 4", rd, lat); else n_pass++;
    n_total++; if (beats.size() != 2 || beats[1].sel !== 4'hF || beats[1].we !== 1'b0) $display("FAIL rd_beat_sel got n=%0d exp sel f", beats.size()); else n_pass++;
    do_data(1'b0, 32'h2001, 32'h0, 4'b0000, rd, lat, ok);
    n_total++; if (rd !== ref_rd(32'h2000)) $display("FAIL rd_merged got=%h exp=%h", rd, ref_rd(32'h2000)); else n_pass++;
    n_total++; if (stab_viol != 0) $display("FAIL hold_stable got=%0d violations exp=0", stab_viol); else n_pass++;
    $display("data_wait: last read=%h", rd);
  endtask

  task automatic test_priority;
    int got[$];
    int exp_ord[4];
    exp_ord = '{1, 2, 1, 2};
    wait_n = 1;
    @(posedge clk); #1 rst = 1'b0;
    i_addr = 32'h1000; i_req = 1'b1;
    d_addr = 32'h3000; d_we = 1'b0; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 200 && got.size() < 4; c++) begin
      @(negedge clk);
      if (d_valid) begin
        got.push_back(1);
        n_total++; if (d_rdata !== 32'hDEADBEEF || d_stall !== 1'b0) $display("FAIL prio_dread got=%h stall=%b exp=deadbeef 0", d_rdata, d_stall); else n_pass++;
      end
      if (i_valid) begin
        got.push_back(2);
        n_total++; if (i_data !== {32'hAAAA0002, 32'hAAAA0001}) $display("FAIL prio_fetch got=%h exp=aaaa0002aaaa0001", i_data); else n_pass++;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    n_total++; if (got.size() != 4) $display("FAIL prio_count got=%0d exp=4", got.size()); else n_pass++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_total++; if (got[k] != exp_ord[k]) $display("FAIL prio_order idx=%0d got=%0d exp=%0d", k, got[k], exp_ord[k]); else n_pass++;
    end
    n_total++; if (ovl_viol != 0) $display("FAIL valid_overlap got=%0d exp=0", ovl_viol); else n_pass++;
    $display("priority: grants=%p", got);
  endtask

  task automatic test_flush;
    int c;
    bit seen;
    logic [DW-1:0] rd;
    int lat;
    bit ok;
    wait_n = 3; beats.delete();
    i_addr = 32'h5000; i_req = 1'b1; i_flush = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (mem_req) seen = 1'b1; end
    n_total++; if (seen) $display("FAIL flush_idle got mem_req=1 exp=0"); else n_pass++;
    i_flush = 1'b0;
    c = 0;
    while (!mem_req && c < 20) begin @(negedge clk); c++; end
    i_flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    c = 0;
    while (beats.size() < 1 && c < 20) begin
      n_total++; if (mem_req !== 1'b1) $display("FAIL flush_hold got mem_req=%b exp=1", mem_req); else n_pass++;
      @(negedge clk); c++;
    end
    @(negedge clk);
    n_total++; if (mem_req !== 1'b0 || i_valid !== 1'b0) $display("FAIL flush_stop got req=%b valid=%b exp=0 0", mem_req, i_valid); else n_pass++;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (i_valid || mem_req) seen = 1'b1; end
    n_total++; if (seen || beats.size() != 1) $display("FAIL flush_quiet got beats=%0d activity=%0d exp=1 0", beats.size(), seen); else n_pass++;
    wait_n = 0;
    do_data(1'b0, 32'h3000, 32'h0, 4'b0, rd, lat, ok);
    n_total++; if (!ok || lat != 2) $display("FAIL flush_idle_after got lat=%0d exp=2", lat); else n_pass++;
    $display("flush: beats=%0d", beats.size());
  endtask

  task automatic test_wrap;
    logic [FN*DW-1:0] data;
    logic [FN*AW-1:0] addrs;
    int lat;
    bit ok;
    wait_n = 0; beats.delete();
    do_fetch(32'hFFFFFFFC, data, addrs, lat, ok);
    n_total++; if (!ok || addrs !== {32'h00000000, 32'hFFFFFFFC}) $display("FAIL wrap_addr got=%h exp=00000000fffffffc", addrs); else n_pass++;
    n_total++; if (data !== {ref_rd(32'h0), ref_rd(32'hFFFFFFFC)}) $display("FAIL wrap_data got=%h exp=%h", data, {ref_rd(32'h0), ref_rd(32'hFFFFFFFC)}); else n_pass++;
    $display("wrap: addrs=%h", addrs);
  endtask

  task automatic test_reset_mid;
    logic [FN*DW-1:0] data;
    logic [FN*AW-1:0] addrs;
    int lat, c;
    bit ok;
    wait_n = 2; beats.delete();
    i_addr = 32'h6000; i_req = 1'b1;
    c = 0;
    while (beats.size() < 1 && c < 30) begin @(negedge clk); c++; end
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (mem_req !== 1'b0 || i_valid !== 1'b0 || d_valid !== 1'b0) $display("FAIL rstmid_ctrl got req=%b iv=%b dv=%b exp=0", mem_req, i_valid, d_valid); else n_pass++;
    n_total++; if (i_data !== '0 || i_addr_o !== '0 || d_rdata !== '0 || mem_addr !== '0 || mem_sel !== '0) $display("FAIL rstmid_regs got=%h %h %h %h exp=0", i_data, i_addr_o, d_rdata, mem_addr); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    beats.delete();
    do_fetch(32'h7000, data, addrs, lat, ok);
    n_total++; if (!ok || lat != FN + 1 + FN * 2) $display("FAIL rstmid_refetch_lat got=%0d exp=%0d", lat, FN + 1 + FN * 2); else n_pass++;
    n_total++; if (data !== {ref_rd(32'h7004), ref_rd(32'h7000)} || addrs !== {32'h7004, 32'h7000}) $display("FAIL rstmid_refetch got=%h exp=%h", data, {ref_rd(32'h7004), ref_rd(32'h7000)}); else n_pass++;
    $display("reset_mid: refetch lat=%0d", lat);
  endtask

  task automatic test_random;
    logic [FN*DW-1:0] data, edata;
    logic [FN*AW-1:0] addrs, eaddrs;
    logic [DW-1:0] rd, wd;
    logic [AW-1:0] a, base;
    logic [SW-1:0] sel;
    int lat, kind, exp_lat;
    bit ok;
    spur_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wait_n = $urandom_range(0, 2);
      kind = $urandom_range(0, 2);
      a = 32'h8000 + AW'($urandom_range(0, 15) * 4) + AW'($urandom_range(0, 3));
      base = a & ~32'h3;
      if (kind == 2) begin
        do_fetch(a, data, addrs, lat, ok);
        exp_lat = FN + 1 + FN * wait_n;
        for (int k = 0; k < FN; k++) begin
          eaddrs[k*AW +: AW] = base + AW'(4 * k);
          edata[k*DW +: DW] = ref_rd(base + AW'(4 * k));
        end
        n_total++; if (!ok || lat != exp_lat || data !== edata || addrs !== eaddrs)
          $display("FAIL rand_fetch t=%0d got=%h/%h lat=%0d exp=%h/%h lat=%0d", t, data, addrs, lat, edata, eaddrs, exp_lat); else n_pass++;
        $display("rand t=%0d fetch a=%h lat=%0d", t, a, lat);
      end else begin
        wd = $urandom;
        sel = SW'($urandom_range(0, 15));
        do_data(kind == 1, a, wd, sel, rd, lat, ok);
        exp_lat = 2 + wait_n;
        if (kind == 1) begin
          ref_mem[base] = merge(ref_rd(base), wd, sel);
          n_total++; if (!ok || lat != exp_lat) $display("FAIL rand_write t=%0d lat=%0d exp=%0d", t, lat, exp_lat); else n_pass++;
        end else begin
          n_total++; if (!ok || lat != exp_lat || rd !== ref_rd(base)) $display("FAIL rand_read t=%0d got=%h lat=%0d exp=%h lat=%0d", t, rd, lat, ref_rd(base), exp_lat); else n_pass++;
        end
        $display("rand t=%0d %s a=%h lat=%0d", t, (kind == 1) ? "write" : "read", a, lat);
      end
    end
    spur_en = 1'b0;
    n_total++; if (stab_viol != 0 || ovl_viol != 0) $display("FAIL rand_protocol got stab=%0d ovl=%0d exp=0 0", stab_viol, ovl_viol); else n_pass++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_basic();
    test_data_wait();
    test_priority();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
